// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the sequential chunked adder/subtractor.
// Saturation limits are used only when ADD_SUB_SATURATE_EN is defined.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation helper can describe; callers slice the low WIDTH bits.
    localparam int SAT_MAX_W = 128;

    // Most positive value (neg = 0) or most negative value (neg = 1) for a signed 'width'-bit number.
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int width, input logic neg);
        logic [SAT_MAX_W-1:0] lim;
        lim = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < width - 1) begin
                lim[i] = ~neg;
            end else if (i == width - 1) begin
                lim[i] = neg;
            end
        end
        return lim;
    endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit ripple adder with carry in/out; one slice of the
// wide operation, reused by the sequencer every BUSY cycle.
module add_sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle two's-complement add/sub, CHUNK bits per clock, LSB chunk first.
// Define ADD_SUB_SATURATE_EN to clamp s to the signed range on overflow.
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam int MSB = WIDTH - 1;

    // Handshake: start is sampled only in IDLE or DONE; busy is high for exactly
    // NCHUNK cycles after acceptance; done then stays high with s/cout/ovf held
    // until the next accepted start. start while busy is ignored.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;          // effective B: already inverted for subtraction
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] s_int_q, s_int_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] s_full;
    logic [WIDTH-1:0] s_res;
    logic             ovf_full;

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    add_sub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Full result as it stands once the current chunk is merged in.
    always_comb begin
        s_full = s_int_q;
        s_full[idx_q*CHUNK +: CHUNK] = chunk_sum;
        ovf_full = (a_q[MSB] == b_q[MSB]) && (s_full[MSB] != a_q[MSB]);
    end

`ifdef ADD_SUB_SATURATE_EN
    logic [SAT_MAX_W-1:0] sat_val;

    always_comb begin
        sat_val = sat_limit(WIDTH, a_q[MSB]);
        s_res   = ovf_full ? sat_val[WIDTH-1:0] : s_full;
    end
`else
    assign s_res = s_full;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_int_d = s_int_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (sel == OP_SUB) ? ~b : b;
                    carry_d = sel;
                    idx_d   = '0;
                    s_int_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_int_d = s_full;
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    s_d     = s_res;
                    cout_d  = chunk_cout;
                    ovf_d   = ovf_full;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_int_q <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_int_q <= s_int_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor. Processes CHUNK bits per clock, LSB chunk first, with a registered carry between chunks. Handshake is start/busy/done. Reports carry-out and signed overflow. Used wherever a wide add/sub must close timing at the cost of WIDTH/CHUNK cycles of latency.

Parameters:
WIDTH, 32, operand/result width in bits
CHUNK, 8, bits processed per cycle; WIDTH % CHUNK must be 0; CHUNK == WIDTH gives single-pass operation
NCHUNK, WIDTH/CHUNK, derived (localparam), number of BUSY cycles

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  operand A, two's complement, sampled with start
b      input   WIDTH  operand B, two's complement, sampled with start
sel    input   1      0 = A+B, 1 = A-B; sampled with start
busy   output  1      high while in BUSY
done   output  1      high while in DONE (result valid)
s      output  WIDTH  result, two's complement
cout   output  1      carry out of MSB (sub: 1 = no borrow)
ovf    output  1      signed overflow

Behaviour:
- Reset: synchronous, active-high, one clock. State = IDLE. busy = 0, done = 0, s = 0, cout = 0, ovf = 0. Internal operand, carry and chunk-index registers are cleared.
- States are IDLE, BUSY and DONE.
- IDLE:
  - On start = 1, latch a, b and sel.
  - Effective B is b_eff = sel ? ~b : b.
  - Carry register = sel.
  - Chunk index = 0. Go to BUSY.
- BUSY:
  - Each cycle adds chunk[idx] of a and b_eff plus the carry register.
  - The CHUNK-bit sum is written into s_int[idx*CHUNK +: CHUNK].
  - The carry register takes the chunk carry-out. idx increments.
  - After the chunk with idx = NCHUNK-1, capture the outputs and go to DONE:
    - s = s_int
    - cout = final carry
    - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB])
- Latency: start is sampled in cycle 0. BUSY occupies cycles 1..NCHUNK. done = 1 from cycle NCHUNK+1.
- DONE:
  - done stays high and s/cout/ovf are held until a new start is accepted.
  - start = 1 in DONE is accepted exactly as in IDLE (back-to-back operation). done drops the next cycle.
  - start = 0 in DONE: stay in DONE.
- start while BUSY is ignored. Operand changes while BUSY have no effect, because operands are latched.
- s, cout and ovf change only on entry to DONE or on reset. They are never partially updated while BUSY.
- rst mid-operation aborts the operation: IDLE, all outputs 0, no done pulse.
- Width rules: all arithmetic is modulo 2^WIDTH. No extension bit is carried in s.

Optional Feature:
- Macro: ADD_SUB_SATURATE_EN.
- When defined, on entry to DONE with ovf = 1, s is clamped:
  - to 2^(WIDTH-1)-1 when a[MSB] = 0;
  - to -2^(WIDTH-1) when a[MSB] = 1.
- ovf still reports 1. cout is unchanged.
- When undefined, s wraps (modulo result). No extra logic is generated.

Decomposition:
- Shared package add_sub_pkg holds:
  - the state typedef (IDLE, BUSY, DONE);
  - the operation encodings OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - a function computing saturation limits for a given WIDTH.
- One sub-module, add_sub_chunk: combinational CHUNK-bit adder with ports a, b, cin, sum, cout. It is instantiated once and reused every BUSY cycle.

Test Plan:
- WIDTH=32, CHUNK=8: a=0x7FFFFFFF, b=1, sel=0 -> done at cycle 5, s=0x80000000, ovf=1, cout=0. With ADD_SUB_SATURATE_EN: s=0x7FFFFFFF.
- a=5, b=7, sel=1 -> s=0xFFFFFFFE, cout=0, ovf=0. Then, in the DONE cycle, start with a=0xFFFFFFFF, b=1, sel=0 -> next result s=0, cout=1, ovf=0, and done is low for exactly 4 cycles.
- a=0x80000000, b=1, sel=1 -> s=0x7FFFFFFF, ovf=1, cout=1. With ADD_SUB_SATURATE_EN: s=0x80000000.
- Start accepted (a=1, b=2, sel=0); pulse start with a=100, b=100 at cycle 2 -> ignored, busy stays high 4 cycles, s=3.
- Start an operation; assert rst at cycle 2 -> the next cycle has busy=0, done=0, s=0. No done appears afterwards until a new start.
- Re-run with CHUNK=32 (NCHUNK=1): a=0x12345678, b=0x11111111, sel=1 -> done at cycle 2, s=0x01234567, cout=1, ovf=0.
